// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch condition resolve with 2-entry result FIFO
// Optional saturating taken/not-taken statistics counters via BRANCH_STATS_EN.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_branch,
  input  logic [2:0]       funct3,
  input  logic             zero_flag,
  input  logic             negative_flag,
  input  logic             carry_flag,
  input  logic             overflow_flag,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic             illegal,
  output logic             misaligned,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] ntaken_count
);

  logic            r_taken      [2];
  logic [XLEN-1:0] r_target     [2];
  logic            r_illegal    [2];
  logic            r_misaligned [2];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_count;

  logic            w_cond;
  logic            w_illegal;
  logic [XLEN-1:0] w_target;
  logic            w_misaligned;
  logic            w_push;
  logic            w_pop;

  always_comb begin
    w_cond    = 1'b0;
    w_illegal = 1'b0;
    if (!is_branch) begin
      w_cond = 1'b1;
    end else begin
      case (funct3)
        3'b000:  w_cond = zero_flag;
        3'b001:  w_cond = ~zero_flag;
        3'b100:  w_cond = negative_flag ^ overflow_flag;
        3'b101:  w_cond = ~(negative_flag ^ overflow_flag);
        3'b110:  w_cond = ~carry_flag;
        3'b111:  w_cond = carry_flag;
        default: w_illegal = 1'b1;
      endcase
    end
  end

  assign w_target     = pc + imm;
  assign w_misaligned = w_cond & (|w_target[1:0]);

  // in_ready depends only on registered occupancy, so a full FIFO never accepts
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign taken      = out_valid & r_taken[r_rd_ptr];
  assign target     = out_valid ? r_target[r_rd_ptr] : '0;
  assign illegal    = out_valid & r_illegal[r_rd_ptr];
  assign misaligned = out_valid & r_misaligned[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_taken[i]      <= 1'b0;
        r_target[i]     <= '0;
        r_illegal[i]    <= 1'b0;
        r_misaligned[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_taken[r_wr_ptr]      <= w_cond;
        r_target[r_wr_ptr]     <= w_target;
        r_illegal[r_wr_ptr]    <= w_illegal;
        r_misaligned[r_wr_ptr] <= w_misaligned;
        r_wr_ptr               <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_taken_count;
  logic [CNT_W-1:0] r_ntaken_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taken_count  <= '0;
      r_ntaken_count <= '0;
    end else if (w_pop) begin
      if (taken && (r_taken_count != {CNT_W{1'b1}})) begin
        r_taken_count <= r_taken_count + 1'b1;
      end
      if (!taken && (r_ntaken_count != {CNT_W{1'b1}})) begin
        r_ntaken_count <= r_ntaken_count + 1'b1;
      end
    end
  end

  assign taken_count  = r_taken_count;
  assign ntaken_count = r_ntaken_count;
`else
  assign taken_count  = '0;
  assign ntaken_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
// Expected counter values follow BRANCH_STATS_EN when defined.
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             is_branch;
  logic [2:0]       funct3;
  logic             zero_flag;
  logic             negative_flag;
  logic             carry_flag;
  logic             overflow_flag;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic [XLEN-1:0]  target;
  logic             illegal;
  logic             misaligned;
  logic [CNT_W-1:0] taken_count;
  logic [CNT_W-1:0] ntaken_count;

  int checks   = 0;
  int failures = 0;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .is_branch     (is_branch),
    .funct3        (funct3),
    .zero_flag     (zero_flag),
    .negative_flag (negative_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .pc            (pc),
    .imm           (imm),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .taken         (taken),
    .target        (target),
    .illegal       (illegal),
    .misaligned    (misaligned),
    .taken_count   (taken_count),
    .ntaken_count  (ntaken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic br, input logic [2:0] f3, input logic z, input logic n,
                          input logic c, input logic v, input logic [31:0] p, input logic [31:0] i);
    is_branch     = br;
    funct3        = f3;
    zero_flag     = z;
    negative_flag = n;
    carry_flag    = c;
    overflow_flag = v;
    pc            = p;
    imm           = i;
  endtask

  task automatic check_head(input string tag, input logic e_taken, input logic [31:0] e_target,
                            input logic e_ill, input logic e_mis);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".taken"}, {31'd0, taken}, {31'd0, e_taken});
    chk({tag, ".target"}, target, e_target);
    chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, e_ill});
    chk({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, e_mis});
  endtask

  task automatic check_counts(input string tag, input int e_t, input int e_n);
`ifdef BRANCH_STATS_EN
    chk({tag, ".taken_count"}, {30'd0, taken_count}, e_t);
    chk({tag, ".ntaken_count"}, {30'd0, ntaken_count}, e_n);
`else
    chk({tag, ".taken_count"}, {30'd0, taken_count}, 32'd0 + 0 * e_t);
    chk({tag, ".ntaken_count"}, {30'd0, ntaken_count}, 32'd0 + 0 * e_n);
`endif
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_beat(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.taken", {31'd0, taken}, 32'd0);
    chk("rst.target", target, 32'd0);
    check_counts("rst", 0, 0);
    rst = 1'b0;
    step();
    chk("idle.out_valid", {31'd0, out_valid}, 32'd0);

    // BEQ taken, then BNE not taken, then a third beat against a full FIFO
    set_beat(1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h20);
    in_valid = 1'b1;
    step();
    check_head("beq", 1'b1, 32'h120, 1'b0, 1'b0);
    chk("beq.in_ready", {31'd0, in_ready}, 32'd1);
    set_beat(1'b1, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h8);
    step();
    chk("full.in_ready", {31'd0, in_ready}, 32'd0);
    check_head("full.head", 1'b1, 32'h120, 1'b0, 1'b0);
    set_beat(1'b1, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h700, 32'h4);
    step();
    chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
    check_head("stall.head", 1'b1, 32'h120, 1'b0, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check_head("bne", 1'b0, 32'h208, 1'b0, 1'b0);
    chk("drain.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("empty.out_valid", {31'd0, out_valid}, 32'd0);
    chk("empty.target", target, 32'd0);
    chk("empty.taken", {31'd0, taken}, 32'd0);
    check_counts("drain1", 1, 1);

    // streaming with out_ready=1: push and pop together each cycle
    in_valid = 1'b1;
    set_beat(1'b1, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h10);
    step();
    check_head("blt", 1'b1, 32'h310, 1'b0, 1'b0);
    set_beat(1'b1, 3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h20);
    step();
    check_head("bge", 1'b0, 32'h320, 1'b0, 1'b0);
    set_beat(1'b1, 3'b110, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h30);
    step();
    check_head("bltu", 1'b0, 32'h330, 1'b0, 1'b0);
    set_beat(1'b1, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h40);
    step();
    check_head("bgeu", 1'b1, 32'h340, 1'b0, 1'b0);
    set_beat(1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0);
    step();
    check_head("ill010", 1'b0, 32'h400, 1'b1, 1'b0);
    set_beat(1'b1, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 32'h404, 32'h0);
    step();
    check_head("ill011", 1'b0, 32'h404, 1'b1, 1'b0);
    set_beat(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h500, 32'h100);
    step();
    check_head("jump", 1'b1, 32'h600, 1'b0, 1'b0);
    set_beat(1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h14);
    step();
    check_head("wrap", 1'b1, 32'h4, 1'b0, 1'b0);
    set_beat(1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h2);
    step();
    check_head("mis", 1'b1, 32'h102, 1'b0, 1'b1);
    set_beat(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h2);
    step();
    check_head("nt_odd", 1'b0, 32'h102, 1'b0, 1'b0);
    in_valid = 1'b0;
    step();
    chk("stream.out_valid", {31'd0, out_valid}, 32'd0);
    check_counts("sat", 3, 3);

    // reset while two entries are queued
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_beat(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h800, 32'h8);
    step();
    step();
    in_valid = 1'b0;
    chk("pre_rst.in_ready", {31'd0, in_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst.taken", {31'd0, taken}, 32'd0);
    chk("mid_rst.target", target, 32'd0);
    check_counts("mid_rst", 0, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst.in_ready", {31'd0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
